block_serializer: RTL

Consumes the 128-bit blocks produced by create_block, or by the AES core downstream of it. Emits each block one byte at a time over a valid/ready byte stream, typically into the UART transmitter.
- Byte 0 is emitted first, mirroring the order in which create_block assembles bytes.
- Input has no backpressure, because create_block only pulses valid_out. A small block FIFO therefore absorbs bursts, and overflow is flagged.

---
 rtl/aes_pkg.sv | 14 +
 rtl/block_fifo.sv | 59 +++++
 rtl/block_serializer.sv | 100 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types for the block datapath: a block is sixteen bytes, byte [0]
// being the first one assembled and the first one sent.
package aes_pkg;

  localparam int BLOCK_BYTES = 16;

  typedef logic [BLOCK_BYTES-1:0][7:0] block_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } serializer_state_t;

endpackage

// File: rtl/block_fifo.sv
// Small block FIFO. A write while full is still accepted when a read happens
// in the same cycle, because the read frees the slot the write lands in.
module block_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     wr_en,
  input  block_t                   wr_data,
  input  logic                     rd_en,
  output block_t                   rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  block_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_wr;
  logic            do_rd;

  // Flags and effective read/write qualification
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_rd   = rd_en & ~empty;
    do_wr   = wr_en & (~full | do_rd);
    rd_data = mem[rd_ptr];
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since pointers gate visibility
  always_ff @(posedge clk_in) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/block_serializer.sv
// Serializes 128-bit blocks into a valid/ready byte stream, byte [0] first.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no block in flight; pops the FIFO head into hold if present
//   SEND  | presenting hold[idx]; advances on each accepted byte
module block_serializer
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  block_t      block_in,
  input  logic        valid_in,
  output logic [7:0]  byte_out,
  output logic        byte_valid_out,
  input  logic        byte_ready_in,
  output logic        block_done_out,
  output logic        overflow_out,
  output logic        busy_out
);

  serializer_state_t        state;
  serializer_state_t        state_next;
  block_t                   hold;
  logic [3:0]               idx;
  block_t                   fifo_rd_data;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     pop;
  logic                     hs;
  logic                     last_hs;
  logic                     drop;

  block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .wr_en   (valid_in),
    .wr_data (block_in),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state, handshake and output decode
  always_comb begin
    state_next     = state;
    pop            = 1'b0;
    hs             = 1'b0;
    last_hs        = 1'b0;
    byte_valid_out = 1'b0;
    byte_out       = 8'h00;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        byte_valid_out = 1'b1;
        byte_out       = hold[idx];
        hs             = byte_ready_in;
        last_hs        = hs && (idx == 4'(BLOCK_BYTES - 1));
        if (last_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A pop this cycle frees a slot, so only a full FIFO without a pop drops
    drop = valid_in & fifo_full & ~pop;
  end

  // State, holding register, byte index and status flags
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      hold           <= '0;
      idx            <= '0;
      block_done_out <= 1'b0;
      overflow_out   <= 1'b0;
      busy_out       <= 1'b0;
    end else begin
      state <= state_next;
      if (pop) begin
        hold <= fifo_rd_data;
        idx  <= '0;
      end else if (hs) begin
        idx <= idx + 4'd1;
      end
      block_done_out <= last_hs;
      if (drop) overflow_out <= 1'b1;
      busy_out <= (fifo_count != '0) || (state != IDLE);
    end
  end

endmodule
